display_controller: RTL and testbench

DISPLAY_CONTROLLER -- requirements
Module: display_controller

---
 rtl/display_controller_if.sv | 44 ++++
 rtl/display_controller.sv | 217 +++++++++++++++++++++
 tb/tb_display_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/display_controller_if.sv
// Bus bundle between the display controller, the tile map RAM, the character
// position sources and the VGA adapter.
//   map_x/map_y            tile address to map RAM
//   sprite_type            tile code from map RAM (one cycle after the address)
//   pacman_orientation     1 = facing left
//   *_vga_x/*_vga_y        top-left pixel of pacman and the four ghosts
//   vga_plot/x/y/color     registered pixel write to the VGA adapter
// master: the display controller. slave: map RAM / sprite sources / VGA side.
interface display_controller_if;
  logic [4:0] map_x;
  logic [4:0] map_y;
  logic [2:0] sprite_type;
  logic       pacman_orientation;
  logic [7:0] pacman_vga_x;
  logic [7:0] pacman_vga_y;
  logic [7:0] ghost1_vga_x;
  logic [7:0] ghost1_vga_y;
  logic [7:0] ghost2_vga_x;
  logic [7:0] ghost2_vga_y;
  logic [7:0] ghost3_vga_x;
  logic [7:0] ghost3_vga_y;
  logic [7:0] ghost4_vga_x;
  logic [7:0] ghost4_vga_y;
  logic       vga_plot;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;

  modport master (
    output map_x, map_y, vga_plot, vga_x, vga_y, vga_color,
    input  sprite_type, pacman_orientation,
    input  pacman_vga_x, pacman_vga_y,
    input  ghost1_vga_x, ghost1_vga_y, ghost2_vga_x, ghost2_vga_y,
    input  ghost3_vga_x, ghost3_vga_y, ghost4_vga_x, ghost4_vga_y
  );

  modport slave (
    input  map_x, map_y, vga_plot, vga_x, vga_y, vga_color,
    output sprite_type, pacman_orientation,
    output pacman_vga_x, pacman_vga_y,
    output ghost1_vga_x, ghost1_vga_y, ghost2_vga_x, ghost2_vga_y,
    output ghost3_vga_x, ghost3_vga_y, ghost4_vga_x, ghost4_vga_y
  );
endinterface

// File: rtl/display_controller.sv
// Redraws one full frame after reset: 32x24 tiles of 5x5 pixels fetched from
// the map RAM, then pacman and ghosts 1..4 as 5x5 bitmaps over the tiles.
// Ports:
//   clock_50  system clock, rising edge
//   reset     synchronous, active-high; releasing it starts a new frame
//   bus       display_controller_if.master (map RAM, sprite positions, VGA)
module display_controller (
  input  logic                        clock_50,
  input  logic                        reset,
  display_controller_if.master        bus
);

  typedef enum logic [2:0] {FETCH, WAIT, TILE_DRAW, CHAR_DRAW, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] tx_q, tx_d, ty_q, ty_d;
  logic [2:0] px_q, px_d, py_q, py_d;
  logic [2:0] ch_q, ch_d;
  logic [2:0] spr_q, spr_d;
  logic [7:0] cx_q [5];
  logic [7:0] cx_d [5];
  logic [7:0] cy_q [5];
  logic [7:0] cy_d [5];
  logic       left_q, left_d;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d, y_q, y_d;
  logic [2:0] color_q, color_d;

  // Tile colour for a pixel of a 5x5 tile; codes 1xx fall into the empty case.
  function automatic logic [2:0] tile_color(input logic [2:0] code,
                                            input logic [2:0] px,
                                            input logic [2:0] py);
    logic [2:0] c;
    c = 3'b000;
    case (code)
      3'b011: c = 3'b001;
      3'b001: if (px == 3'd2 && py == 3'd2) c = 3'b111;
      3'b010: if (px >= 3'd1 && px <= 3'd3 && py >= 3'd1 && py <= 3'd3) c = 3'b111;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

  // One bitmap row, bit index = px. Character 0 is pacman, 1..4 the ghosts.
  function automatic logic [4:0] char_row(input logic [2:0] ch,
                                          input logic [2:0] py,
                                          input logic       left);
    logic [4:0] r;
    if (ch == 3'd0) begin
      case (py)
        3'd0:    r = 5'b01110;
        3'd1:    r = 5'b11111;
        3'd2:    r = left ? 5'b11100 : 5'b00111;  // mouth opens toward facing side
        3'd3:    r = 5'b11111;
        default: r = 5'b01110;
      endcase
    end else begin
      case (py)
        3'd0:    r = 5'b01110;
        3'd4:    r = 5'b10101;
        default: r = 5'b11111;
      endcase
    end
    return r;
  endfunction

  function automatic logic [2:0] char_color(input logic [2:0] ch);
    logic [2:0] c;
    case (ch)
      3'd0:    c = 3'b110;
      3'd1:    c = 3'b100;
      3'd2:    c = 3'b011;
      3'd3:    c = 3'b101;
      default: c = 3'b010;
    endcase
    return c;
  endfunction

  logic       last_px, last_pix;
  logic [2:0] px_nxt, py_nxt;
  logic [7:0] tile_x, tile_y;
  logic [7:0] cur_x, cur_y;
  logic [8:0] char_sx, char_sy;
  logic [4:0] char_bits;

  assign last_px  = (px_q == 3'd4);
  assign last_pix = last_px && (py_q == 3'd4);
  assign px_nxt   = last_px ? 3'd0 : px_q + 3'd1;
  assign py_nxt   = last_px ? ((py_q == 3'd4) ? 3'd0 : py_q + 3'd1) : py_q;

  // 5*t as (t<<2)+t; largest value 155 so 8 bits suffice.
  assign tile_x = {1'b0, tx_q, 2'b00} + {3'b000, tx_q};
  assign tile_y = {1'b0, ty_q, 2'b00} + {3'b000, ty_q};

  always_comb begin
    cur_x = cx_q[0];
    cur_y = cy_q[0];
    case (ch_q)
      3'd1:    begin cur_x = cx_q[1]; cur_y = cy_q[1]; end
      3'd2:    begin cur_x = cx_q[2]; cur_y = cy_q[2]; end
      3'd3:    begin cur_x = cx_q[3]; cur_y = cy_q[3]; end
      3'd4:    begin cur_x = cx_q[4]; cur_y = cy_q[4]; end
      default: begin cur_x = cx_q[0]; cur_y = cy_q[0]; end
    endcase
  end

  // 9-bit sums so pixels past the right/bottom edge are clipped, not wrapped.
  assign char_sx   = {1'b0, cur_x} + {6'b000000, px_q};
  assign char_sy   = {1'b0, cur_y} + {6'b000000, py_q};
  assign char_bits = char_row(ch_q, py_q, left_q);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    px_d    = px_q;
    py_d    = py_q;
    ch_d    = ch_q;
    spr_d   = spr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    left_d  = left_q;
    plot_d  = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    case (state_q)
      FETCH: state_d = WAIT;
      WAIT: begin
        spr_d   = bus.sprite_type;
        state_d = TILE_DRAW;
      end
      TILE_DRAW: begin
        plot_d  = 1'b1;
        x_d     = tile_x + {5'b00000, px_q};
        y_d     = tile_y + {5'b00000, py_q};
        color_d = tile_color(spr_q, px_q, py_q);
        px_d    = px_nxt;
        py_d    = py_nxt;
        if (last_pix) begin
          state_d = FETCH;
          if (tx_q == 5'd31) begin
            tx_d = 5'd0;
            if (ty_q == 5'd23) begin
              ty_d    = 5'd0;
              ch_d    = 3'd0;
              state_d = CHAR_DRAW;
              // Positions are snapshotted so a moving sprite cannot tear.
              cx_d[0] = bus.pacman_vga_x;  cy_d[0] = bus.pacman_vga_y;
              cx_d[1] = bus.ghost1_vga_x;  cy_d[1] = bus.ghost1_vga_y;
              cx_d[2] = bus.ghost2_vga_x;  cy_d[2] = bus.ghost2_vga_y;
              cx_d[3] = bus.ghost3_vga_x;  cy_d[3] = bus.ghost3_vga_y;
              cx_d[4] = bus.ghost4_vga_x;  cy_d[4] = bus.ghost4_vga_y;
              left_d  = bus.pacman_orientation;
            end else begin
              ty_d = ty_q + 5'd1;
            end
          end else begin
            tx_d = tx_q + 5'd1;
          end
        end
      end
      CHAR_DRAW: begin
        plot_d  = char_bits[px_q] && (char_sx <= 9'd159) && (char_sy <= 9'd119);
        x_d     = char_sx[7:0];
        y_d     = char_sy[7:0];
        color_d = char_color(ch_q);
        px_d    = px_nxt;
        py_d    = py_nxt;
        if (last_pix) begin
          if (ch_q == 3'd4) state_d = DONE;
          else              ch_d    = ch_q + 3'd1;
        end
      end
      DONE: state_d = DONE;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock_50) begin
    spr_q  <= spr_d;
    cx_q   <= cx_d;
    cy_q   <= cy_d;
    left_q <= left_d;
    if (reset) begin
      state_q <= FETCH;
      tx_q    <= 5'd0;
      ty_q    <= 5'd0;
      px_q    <= 3'd0;
      py_q    <= 3'd0;
      ch_q    <= 3'd0;
      plot_q  <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      color_q <= 3'b000;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ch_q    <= ch_d;
      plot_q  <= plot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
    end
  end

  assign bus.map_x     = tx_q;
  assign bus.map_y     = ty_q;
  assign bus.vga_plot  = plot_q;
  assign bus.vga_x     = x_q;
  assign bus.vga_y     = y_q;
  assign bus.vga_color = color_q;

endmodule

// File: tb/tb_display_controller.sv
module tb_display_controller;
  logic clock_50 = 1'b0;
  logic reset    = 1'b1;
  int   tests    = 0;
  int   fails    = 0;
  int   mode     = 0;
  int   cxs [5];
  int   cys [5];
  logic orient;

  display_controller_if bus();

  display_controller dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_50 = ~clock_50;

  // Map RAM contents: mode 0 is all walls; mode 1 has a bean at (3,2), a
  // pellet at (10,20), codes 111/100 at (11,20)/(12,20), everything else empty.
  function automatic logic [2:0] map_code(input int m, input int tx, input int ty);
    if (m == 0) return 3'b011;
    if (tx == 3  && ty == 2)  return 3'b001;
    if (tx == 10 && ty == 20) return 3'b010;
    if (tx == 11 && ty == 20) return 3'b111;
    if (tx == 12 && ty == 20) return 3'b100;
    return 3'b000;
  endfunction

  // Map RAM read latency of one cycle.
  always @(posedge clock_50) bus.sprite_type <= map_code(mode, int'(bus.map_x), int'(bus.map_y));

  function automatic int exp_tile_color(input logic [2:0] code, input int px, input int py);
    if (code == 3'b011) return 1;
    if (code == 3'b001) return (px == 2 && py == 2) ? 7 : 0;
    if (code == 3'b010) return (px >= 1 && px <= 3 && py >= 1 && py <= 3) ? 7 : 0;
    return 0;
  endfunction

  function automatic bit char_pixel(input int ch, input int px, input int py, input logic left);
    string rows [5];
    string r;
    if (ch == 0 && !left)     rows = '{".###.", "#####", "###..", "#####", ".###."};
    else if (ch == 0 && left) rows = '{".###.", "#####", "..###", "#####", ".###."};
    else                      rows = '{".###.", "#####", "#####", "#####", "#.#.#"};
    r = rows[py];
    return r.getc(px) == 8'h23;
  endfunction

  function automatic int exp_char_color(input int ch);
    case (ch)
      0: return 6;
      1: return 4;
      2: return 3;
      3: return 5;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_chars();
    bus.pacman_vga_x = 8'(cxs[0]); bus.pacman_vga_y = 8'(cys[0]);
    bus.ghost1_vga_x = 8'(cxs[1]); bus.ghost1_vga_y = 8'(cys[1]);
    bus.ghost2_vga_x = 8'(cxs[2]); bus.ghost2_vga_y = 8'(cys[2]);
    bus.ghost3_vga_x = 8'(cxs[3]); bus.ghost3_vga_y = 8'(cys[3]);
    bus.ghost4_vga_x = 8'(cxs[4]); bus.ghost4_vga_y = 8'(cys[4]);
    bus.pacman_orientation = orient;
  endtask

  // Frame statistics gathered by run_frame.
  int   tile_plots, c001_plots, nonblack, model_bad, map32, pac_plots, g4_plots, oob, done_bad;
  logic seen_13_7, seen_14_7, seen_10_7, seen_11_7, seen_12_7, bean_ok;
  logic s3_p, slt_p, s20860_p, s20861_p;
  logic [7:0] s3_x, s3_y, slt_x, slt_y, s20861_x, s20861_y;
  logic [2:0] s20861_c;

  // Sample k (k>=1) is taken 1 time unit after the k-th rising edge following
  // reset release, so it shows the pixel of draw cycle k-1. Tiles take 27
  // cycles each (FETCH, WAIT, 25 pixels), characters 25 cycles each.
  task automatic run_frame(input int m);
    int d, t, r, p, px, py, tx, ty, ch, sx, sy, ex, ey, ec;
    logic ep;
    tile_plots = 0; c001_plots = 0; nonblack = 0; model_bad = 0; map32 = 0;
    pac_plots = 0; g4_plots = 0; oob = 0; done_bad = 0;
    seen_13_7 = 0; seen_14_7 = 0; seen_10_7 = 0; seen_11_7 = 0; seen_12_7 = 0; bean_ok = 0;
    for (int k = 1; k <= 20870; k++) begin
      @(posedge clock_50); #1;
      ep = 1'b0; ex = 0; ey = 0; ec = 0;
      if (k <= 20736) begin
        d = k - 1; t = d / 27; r = d % 27; tx = t % 32; ty = t / 32;
        if (r >= 2) begin
          p = r - 2; px = p % 5; py = p / 5;
          ep = 1'b1; ex = 5 * tx + px; ey = 5 * ty + py;
          ec = exp_tile_color(map_code(m, tx, ty), px, py);
        end
        if (bus.map_x == 5'd3 && bus.map_y == 5'd2) map32++;
        if (bus.vga_plot === 1'b1) begin
          tile_plots++;
          if (bus.vga_color == 3'b001) c001_plots++;
          if (bus.vga_color != 3'b000) nonblack++;
          if (bus.vga_x == 8'd17 && bus.vga_y == 8'd12 && bus.vga_color == 3'b111) bean_ok = 1'b1;
        end
      end else if (k <= 20861) begin
        d = k - 1 - 20736; ch = d / 25; p = d % 25; px = p % 5; py = p / 5;
        sx = cxs[ch] + px; sy = cys[ch] + py;
        ep = char_pixel(ch, px, py, orient) && sx <= 159 && sy <= 119;
        ex = sx; ey = sy; ec = exp_char_color(ch);
        if (bus.vga_plot === 1'b1) begin
          if (bus.vga_color == 3'b110) pac_plots++;
          if (bus.vga_color == 3'b010) g4_plots++;
          if (bus.vga_x > 8'd159 || bus.vga_y > 8'd119) oob++;
          if (bus.vga_y == 8'd7) begin
            if (bus.vga_x == 8'd10) seen_10_7 = 1'b1;
            if (bus.vga_x == 8'd11) seen_11_7 = 1'b1;
            if (bus.vga_x == 8'd12) seen_12_7 = 1'b1;
            if (bus.vga_x == 8'd13) seen_13_7 = 1'b1;
            if (bus.vga_x == 8'd14) seen_14_7 = 1'b1;
          end
        end
      end else begin
        if (bus.vga_plot !== 1'b0 || bus.map_x !== 5'd0 || bus.map_y !== 5'd0) done_bad++;
      end
      if (bus.vga_plot !== ep) model_bad++;
      else if (ep && (bus.vga_x !== ex[7:0] || bus.vga_y !== ey[7:0] || bus.vga_color !== ec[2:0]))
        model_bad++;
      if (k == 3)     begin s3_p = bus.vga_plot; s3_x = bus.vga_x; s3_y = bus.vga_y; end
      if (k == 20736) begin slt_p = bus.vga_plot; slt_x = bus.vga_x; slt_y = bus.vga_y; end
      if (k == 20860) s20860_p = bus.vga_plot;
      if (k == 20861) begin
        s20861_p = bus.vga_plot; s20861_x = bus.vga_x; s20861_y = bus.vga_y; s20861_c = bus.vga_color;
      end
    end
  endtask

  initial begin
    int viol;
    // Frame 1: all walls; pacman at (10,5) facing right; ghost4 at the corner.
    mode = 0;
    cxs = '{10, 20, 30, 40, 157};
    cys = '{5, 20, 20, 20, 118};
    orient = 1'b0;
    drive_chars();
    reset = 1'b1;
    repeat (3) @(posedge clock_50);
    #1;
    check("reset_plot",  bus.vga_plot,  0);
    check("reset_x",     bus.vga_x,     0);
    check("reset_y",     bus.vga_y,     0);
    check("reset_color", bus.vga_color, 0);
    check("reset_map",   {bus.map_x, bus.map_y}, 0);
    @(negedge clock_50) reset = 1'b0;
    run_frame(0);
    check("f1_model_mismatches", model_bad, 0);
    check("f1_tile_plots",       tile_plots, 768 * 25);
    check("f1_wall_color_plots", c001_plots, 768 * 25);
    check("f1_first_plot",       s3_p, 1);
    check("f1_first_xy",         {s3_x, s3_y}, {8'd0, 8'd0});
    check("f1_last_tile_plot",   slt_p, 1);
    check("f1_last_tile_xy",     {slt_x, slt_y}, {8'd159, 8'd119});
    // Pacman bitmap rows hold 3+5+3+5+3 set pixels.
    check("f1_pacman_plots",     pac_plots, 19);
    check("f1_mouth_13_7",       seen_13_7, 0);
    check("f1_mouth_14_7",       seen_14_7, 0);
    check("f1_ghost4_clipped",   g4_plots, 5);
    check("f1_no_wrapped",       oob, 0);
    check("f1_done_quiet",       done_bad, 0);

    // Reset while in DONE, then frame 2 with a reset pulse 5000 cycles in.
    mode = 1;
    cxs = '{10, 60, 70, 80, 50};
    cys = '{5, 40, 40, 40, 50};
    orient = 1'b1;
    drive_chars();
    @(negedge clock_50) reset = 1'b1;
    @(posedge clock_50); #1;
    check("done_reset_plot", bus.vga_plot, 0);
    check("done_reset_map",  {bus.map_x, bus.map_y}, 0);
    @(negedge clock_50) reset = 1'b0;
    repeat (5000) @(posedge clock_50);
    @(negedge clock_50) reset = 1'b1;
    viol = 0;
    repeat (3) begin
      @(posedge clock_50); #1;
      if (bus.vga_plot !== 1'b0 || bus.vga_x !== 8'd0 || bus.vga_y !== 8'd0 ||
          bus.vga_color !== 3'd0 || bus.map_x !== 5'd0 || bus.map_y !== 5'd0) viol++;
    end
    check("midframe_reset_quiet", viol, 0);
    @(negedge clock_50) reset = 1'b0;
    run_frame(1);
    check("f2_model_mismatches", model_bad, 0);
    check("f2_tile_plots",       tile_plots, 768 * 25);
    check("f2_first_xy",         {s3_p, s3_x, s3_y}, {1'b1, 8'd0, 8'd0});
    // One bean pixel plus the 3x3 pellet centre.
    check("f2_nonblack_tiles",   nonblack, 10);
    check("f2_bean_17_12",       bean_ok, 1);
    check("f2_addr_hold_3_2",    map32, 27);
    check("f2_pacman_plots",     pac_plots, 19);
    check("f2_mouth_10_7",       seen_10_7, 0);
    check("f2_mouth_11_7",       seen_11_7, 0);
    check("f2_body_12_7",        seen_12_7, 1);
    check("f2_ghost4_gap_plot",  s20860_p, 0);
    check("f2_last_plot",        s20861_p, 1);
    check("f2_last_xy",          {s20861_x, s20861_y}, {8'd54, 8'd54});
    check("f2_last_color",       s20861_c, 3'b010);
    check("f2_done_quiet",       done_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
